echo_measure: RTL and testbench
===============================

# echo_measure

Ultrasonic ranging stage directly downstream of the trigger generator. After each trigger pulse completes, it synchronises the sensor's echo line and times the echo-high pulse in microseconds. It converts that width to centimetres with a sequential divider, then returns an echo-done strobe to the trigger generator to close the ranging loop.

## Interface
Parameters:
- CLKS_PER_US, 50, clock cycles per microsecond (50 MHz system clock)
- US_WIDTH, 16, width of microsecond counter and dividend
- DIST_WIDTH, 10, width of distance result
- CM_DIVISOR, 58, microseconds of echo per centimetre
- RISE_TIMEOUT_US, 2000, max wait from start to echo rising edge
- MAX_ECHO_US, 30000, max accepted echo-high width

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- start  input  1  one-cycle pulse from trigger generator's done; begins a measurement
- echo  input  1  raw sensor echo line, asynchronous to clk
- distance  output  DIST_WIDTH  last valid distance in cm, held between measurements
- valid  output  1  one-cycle pulse, distance updated this cycle
- error  output  1  last measurement failed (timeout/overrange); held until next accepted start
- echoDone  output  1  one-cycle pulse at end of every measurement, good or failed
- busy  output  1  high in any state other than IDLE

## Operation
- Echo passes through a 2-flop synchroniser, then a third register for edge detection; all decisions use synchronised echo.
- States: IDLE, WAIT_RISE, MEASURE, CONVERT, DONE.
- IDLE: busy=0. start=1 -> WAIT_RISE; clears error, us counter, prescaler.
- WAIT_RISE: prescaler counts 0..CLKS_PER_US-1; us counter increments on wrap. Sync-echo rising edge -> MEASURE with prescaler and us counter cleared. A level already high on entry is not an edge. us counter reaching RISE_TIMEOUT_US -> DONE with error=1.
- MEASURE: same prescaler/us counting while sync echo high. Falling edge -> CONVERT. us counter reaching MAX_ECHO_US -> DONE with error=1 (do not wait for fall).
- CONVERT: restoring divider, us count / CM_DIVISOR, one quotient bit per cycle, MSB first, exactly US_WIDTH cycles. Quotient truncated (floor) to DIST_WIDTH bits; remainder discarded. Then -> DONE, loading distance.
- DONE: one cycle; echoDone=1; valid=1 only if error=0. Next state IDLE.
- start outside IDLE is ignored (no queuing).
- On error, distance keeps its previous value.
- rst=0 at any time: state IDLE, counters, synchroniser and all outputs cleared immediately.

## Timing
- Reset values: distance=0, valid=0, error=0, echoDone=0, busy=0.
- Edge latency: echo pin change seen as edge 3 clk later; rise and fall delays cancel in width.
- Measured us = floor(high_cycles / CLKS_PER_US), ±1 us from synchroniser alignment.
- Falling edge detect -> CONVERT next cycle -> US_WIDTH cycles -> DONE cycle: valid/echoDone assert US_WIDTH+1 cycles after fall detection.
- busy rises the cycle after accepted start, falls the cycle after DONE.
- error asserts in the DONE cycle and stays until next accepted start.
- Rise timeout: DONE at RISE_TIMEOUT_US·CLKS_PER_US (+1) cycles after start.
- Simultaneous falling edge and MAX_ECHO_US: overrange wins (error).
- Simultaneous rising edge and RISE_TIMEOUT_US: timeout wins.

## Test plan
- Reset: rst=0 mid-MEASURE -> all outputs 0, busy=0 next edge. After release, start + 580 us echo -> distance=10, valid=1, error=0.
- Nominal: start, echo rises 500 us later, high 1160 us -> distance=20, single valid and echoDone pulse 17 cycles after fall detection.
- Short pulse: echo high 40 us -> distance=0, valid=1 (floor).
- No echo: start, echo stays low -> echoDone at 100000 (+1) cycles, error=1, valid=0, distance unchanged from prior 20.
- Overrange: echo held high 40 ms -> echoDone when count hits 30000 us, error=1. Next start clears error.
- Busy guard: second start pulse during MEASURE -> ignored, exactly one echoDone. Echo already high at start -> no rise seen, timeout error.

Source files
------------

// File: rtl/echo_measure.sv
`default_nettype none
// ============================================================================
// echo_measure : times a synchronised ultrasonic echo pulse in us, converts to cm
// Revision     : 1.0
// ============================================================================
module echo_measure #(
  parameter int CLKS_PER_US     = 50,
  parameter int US_WIDTH        = 16,
  parameter int DIST_WIDTH      = 10,
  parameter int CM_DIVISOR      = 58,
  parameter int RISE_TIMEOUT_US = 2000,
  parameter int MAX_ECHO_US     = 30000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  echo,
  output logic [DIST_WIDTH-1:0] distance,
  output logic                  valid,
  output logic                  error,
  output logic                  echoDone,
  output logic                  busy
);

  localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam int CW = $clog2(US_WIDTH + 1);
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLKS_PER_US - 1);
  localparam logic [US_WIDTH-1:0] TIMEOUT_C = US_WIDTH'(RISE_TIMEOUT_US);
  localparam logic [US_WIDTH-1:0] MAX_C     = US_WIDTH'(MAX_ECHO_US);
  localparam logic [US_WIDTH:0]   DIV_C     = (US_WIDTH + 1)'(CM_DIVISOR);
  localparam logic [CW-1:0]       LAST_BIT  = CW'(US_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_RISE = 3'd1,
    S_MEASURE   = 3'd2,
    S_CONVERT   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  echo_s1_q, echo_s2_q, echo_s3_q;
  logic [PW-1:0]         presc_q, presc_d, presc_inc;
  logic [US_WIDTH-1:0]   us_q, us_d, us_inc;
  logic [US_WIDTH-1:0]   quot_q, quot_d;
  logic [US_WIDTH:0]     rem_q, rem_d, shifted, trial;
  logic [CW-1:0]         bit_q, bit_d;
  logic                  error_q, error_d;
  logic [DIST_WIDTH-1:0] dist_q, dist_d;
  logic                  us_tick, rise, fall;

  assign rise      = echo_s2_q & ~echo_s3_q;
  assign fall      = ~echo_s2_q & echo_s3_q;
  assign us_tick   = (presc_q == PRESC_LAST);
  assign presc_inc = us_tick ? '0 : presc_q + 1'b1;
  assign us_inc    = us_tick ? us_q + 1'b1 : us_q;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    us_d    = us_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    error_d = error_q;
    dist_d  = dist_q;
    shifted = {rem_q[US_WIDTH-1:0], quot_q[US_WIDTH-1]};
    trial   = shifted - DIV_C;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_RISE;
          error_d = 1'b0;
          presc_d = '0;
          us_d    = '0;
        end
      end
      S_WAIT_RISE: begin
        // Timeout is checked first so it wins over a coincident rising edge.
        if (us_q >= TIMEOUT_C) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else if (rise) begin
          state_d = S_MEASURE;
          presc_d = '0;
          us_d    = '0;
        end else begin
          presc_d = presc_inc;
          us_d    = us_inc;
        end
      end
      S_MEASURE: begin
        // The fall-detect cycle is still counted; it balances the uncounted rise-detect cycle.
        if (us_q >= MAX_C) begin
          state_d = S_DONE;
          error_d = 1'b1;
        end else begin
          presc_d = presc_inc;
          us_d    = us_inc;
          if (fall) begin
            state_d = S_CONVERT;
            quot_d  = us_inc;
            rem_d   = '0;
            bit_d   = '0;
          end
        end
      end
      S_CONVERT: begin
        rem_d  = trial[US_WIDTH] ? shifted : trial;
        quot_d = {quot_q[US_WIDTH-2:0], ~trial[US_WIDTH]};
        bit_d  = bit_q + 1'b1;
        if (bit_q == LAST_BIT) begin
          state_d = S_DONE;
          dist_d  = quot_d[DIST_WIDTH-1:0];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      echo_s1_q <= 1'b0;
      echo_s2_q <= 1'b0;
      echo_s3_q <= 1'b0;
      presc_q   <= '0;
      us_q      <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      bit_q     <= '0;
      error_q   <= 1'b0;
      dist_q    <= '0;
    end else begin
      state_q   <= state_d;
      echo_s1_q <= echo;
      echo_s2_q <= echo_s1_q;
      echo_s3_q <= echo_s2_q;
      presc_q   <= presc_d;
      us_q      <= us_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      bit_q     <= bit_d;
      error_q   <= error_d;
      dist_q    <= dist_d;
    end
  end

  assign distance = dist_q;
  assign error    = error_q;
  assign echoDone = (state_q == S_DONE);
  assign valid    = (state_q == S_DONE) && !error_q;
  assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_echo_measure.sv
`default_nettype none
// ============================================================================
// tb_echo_measure : randomized and directed checks of echo_measure against a range model
// Revision        : 1.0
// ============================================================================
module tb_echo_measure;

  localparam int C    = 2;
  localparam int TO   = 600;
  localparam int MX   = 3000;
  localparam int DIV  = 58;
  localparam int DW   = 10;
  localparam int HARD = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          echo;
  logic [DW-1:0] distance;
  logic          valid, error, echo_done, busy;

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] model_dist = '0;

  echo_measure #(
    .CLKS_PER_US(C), .US_WIDTH(16), .DIST_WIDTH(DW), .CM_DIVISOR(DIV),
    .RISE_TIMEOUT_US(TO), .MAX_ECHO_US(MX)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .echo(echo),
    .distance(distance), .valid(valid), .error(error),
    .echoDone(echo_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model of one measurement outcome: timeout/overrange keep the old distance.
  function automatic logic [DW-1:0] ref_dist(input int width_us, input bit err);
    int q;
    q = width_us / DIV;
    return err ? model_dist : DW'(q);
  endfunction

  // Runs one start plus an echo schedule (cycles relative to the first idle-start negedge)
  // and records what the DUT reported; rise_at < 0 means echo was already high at start.
  task automatic do_measure(input int rise_at, input int width_cyc, input int extra_start_at,
                            output int done_at, output int n_done,
                            output logic dv, output logic de, output logic [DW-1:0] dd,
                            output logic busy_pre, output logic busy_k0,
                            output logic busy_post, output logic err_k0);
    int sched_end;
    int k;
    bit fin;
    done_at = -1; n_done = 0; dv = 1'b0; de = 1'b0; dd = '0;
    busy_k0 = 1'b0; busy_post = 1'b1; err_k0 = 1'b1;
    if (rise_at < 0) begin
      echo = 1'b1;
      repeat (4) @(negedge clk);
    end
    sched_end = ((rise_at < 0) ? 0 : rise_at) + width_cyc;
    busy_pre = busy;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    fin = 1'b0;
    while (!fin) begin
      if (rise_at < 0) echo = (k < width_cyc);
      else             echo = (k >= rise_at) && (k < rise_at + width_cyc);
      start = (k == extra_start_at);
      if (k == 0) begin
        busy_k0 = busy;
        err_k0  = error;
      end
      if (echo_done) begin
        n_done++;
        if (done_at < 0) begin
          done_at = k; dv = valid; de = error; dd = distance;
        end
      end
      if (done_at >= 0 && k == done_at + 1) busy_post = busy;
      k++;
      @(negedge clk);
      if (done_at >= 0 && k > done_at + 10 && k > sched_end) fin = 1'b1;
      if (k >= HARD) fin = 1'b1;
    end
    start = 1'b0;
    echo  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int da, nd; logic dv, de, bp, b0, bq, e0; logic [DW-1:0] dd;
    rst = 1'b0; start = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({distance, valid, error, echo_done, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got dist=%0d v=%b e=%b done=%b busy=%b, want all 0",
               distance, valid, error, echo_done, busy);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // Put a non-zero distance in place so that the reset clear is observable.
    do_measure(10, 116 * C, -1, da, nd, dv, de, dd, bp, b0, bq, e0);
    model_dist = ref_dist(116, 1'b0);
    n_vec++;
    if (dd !== model_dist || dv !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_meas: got dist=%0d v=%b, want dist=%0d v=1", dd, dv, model_dist);
    end
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    echo = 1'b1;
    repeat (100) @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_in_measure: got %b, want 1", busy);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({distance, valid, error, echo_done, busy} !== '0) begin
      n_err++;
      $display("FAIL async_reset: got dist=%0d v=%b e=%b done=%b busy=%b, want all 0",
               distance, valid, error, echo_done, busy);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b, want 0", busy);
    end
    echo = 1'b0;
    model_dist = '0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    do_measure(20, 580 * C, -1, da, nd, dv, de, dd, bp, b0, bq, e0);
    model_dist = ref_dist(580, 1'b0);
    n_vec++;
    if (dd !== model_dist || dv !== 1'b1 || de !== 1'b0 || model_dist !== DW'(10)) begin
      n_err++;
      $display("FAIL post_reset_580us: got dist=%0d v=%b e=%b, want dist=10 v=1 e=0", dd, dv, de);
    end
  endtask

  task automatic test_short();
    int da, nd; logic dv, de, bp, b0, bq, e0; logic [DW-1:0] dd;
    do_measure(30, 40 * C, -1, da, nd, dv, de, dd, bp, b0, bq, e0);
    model_dist = ref_dist(40, 1'b0);
    n_vec++;
    if (dd !== model_dist || dv !== 1'b1 || de !== 1'b0 || nd != 1) begin
      n_err++;
      $display("FAIL short_40us: got dist=%0d v=%b e=%b pulses=%0d, want dist=%0d v=1 e=0 pulses=1",
               dd, dv, de, nd, model_dist);
    end
  endtask

  task automatic test_nominal();
    int da, nd, lat; logic dv, de, bp, b0, bq, e0; logic [DW-1:0] dd;
    do_measure(500 * C, 1160 * C, -1, da, nd, dv, de, dd, bp, b0, bq, e0);
    model_dist = ref_dist(1160, 1'b0);
    lat = da - (500 * C + 1160 * C);
    n_vec++;
    if (dd !== model_dist || dv !== 1'b1 || de !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_dist: got dist=%0d v=%b e=%b, want dist=%0d v=1 e=0", dd, dv, de, model_dist);
    end
    n_vec++;
    if (nd != 1) begin
      n_err++;
      $display("FAIL nominal_pulses: got %0d echoDone pulses, want 1", nd);
    end
    // Two synchroniser clocks to detect the fall, then US_WIDTH+1 clocks to DONE.
    n_vec++;
    if (lat < 18 || lat > 20) begin
      n_err++;
      $display("FAIL nominal_latency: got %0d clk from pin fall, want 18..20", lat);
    end
    n_vec++;
    if (bp !== 1'b0 || b0 !== 1'b1 || bq !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_busy: got pre=%b after_start=%b after_done=%b, want 0 1 0", bp, b0, bq);
    end
  endtask

  task automatic test_no_echo();
    int da, nd; logic dv, de, bp, b0, bq, e0; logic [DW-1:0] dd;
    do_measure(0, 0, -1, da, nd, dv, de, dd, bp, b0, bq, e0);
    model_dist = ref_dist(0, 1'b1);
    n_vec++;
    if (de !== 1'b1 || dv !== 1'b0 || dd !== model_dist || dd !== DW'(20)) begin
      n_err++;
      $display("FAIL no_echo: got e=%b v=%b dist=%0d, want e=1 v=0 dist=20", de, dv, dd);
    end
    n_vec++;
    if (da < TO * C - 1 || da > TO * C + 2) begin
      n_err++;
      $display("FAIL no_echo_timing: got echoDone at %0d clk, want %0d..%0d", da, TO * C - 1, TO * C + 2);
    end
  endtask

  task automatic test_overrange();
    int da, nd, rel; logic dv, de, bp, b0, bq, e0; logic [DW-1:0] dd;
    do_measure(20, 4000 * C, -1, da, nd, dv, de, dd, bp, b0, bq, e0);
    model_dist = ref_dist(4000, 1'b1);
    rel = da - 20;
    n_vec++;
    if (de !== 1'b1 || dv !== 1'b0 || dd !== model_dist || nd != 1) begin
      n_err++;
      $display("FAIL overrange: got e=%b v=%b dist=%0d pulses=%0d, want e=1 v=0 dist=%0d pulses=1",
               de, dv, dd, nd, model_dist);
    end
    n_vec++;
    if (rel < MX * C + 1 || rel > MX * C + 6) begin
      n_err++;
      $display("FAIL overrange_timing: got echoDone %0d clk after rise, want %0d..%0d", rel, MX * C + 1, MX * C + 6);
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (error !== 1'b1 || valid !== 1'b0) begin
      n_err++;
      $display("FAIL error_held: got e=%b v=%b, want e=1 v=0", error, valid);
    end
  endtask

  task automatic test_busy_guard();
    int da, nd; logic dv, de, bp, b0, bq, e0; logic [DW-1:0] dd;
    do_measure(10, 300 * C, 10 + 100, da, nd, dv, de, dd, bp, b0, bq, e0);
    model_dist = ref_dist(300, 1'b0);
    n_vec++;
    if (e0 !== 1'b0) begin
      n_err++;
      $display("FAIL error_cleared_by_start: got %b, want 0", e0);
    end
    n_vec++;
    if (nd != 1 || dd !== model_dist || dv !== 1'b1 || de !== 1'b0) begin
      n_err++;
      $display("FAIL busy_guard: got pulses=%0d dist=%0d v=%b e=%b, want pulses=1 dist=%0d v=1 e=0",
               nd, dd, dv, de, model_dist);
    end
    do_measure(-1, TO * C + 300, -1, da, nd, dv, de, dd, bp, b0, bq, e0);
    model_dist = ref_dist(0, 1'b1);
    n_vec++;
    if (nd != 1 || de !== 1'b1 || dv !== 1'b0 || dd !== model_dist) begin
      n_err++;
      $display("FAIL echo_high_at_start: got pulses=%0d e=%b v=%b dist=%0d, want pulses=1 e=1 v=0 dist=%0d",
               nd, de, dv, dd, model_dist);
    end
  endtask

  task automatic test_random();
    int da, nd, w, dly, lat; logic dv, de, bp, b0, bq, e0; logic [DW-1:0] dd; logic [DW-1:0] exp_d;
    for (int t = 0; t < 8; t++) begin
      w = $urandom_range(1, 1500);
      // Keep clear of cm boundaries so the allowed +-1 us cannot flip the answer.
      if ((w % DIV) == 0 || (w % DIV) == DIV - 1) w = w + 2;
      dly = $urandom_range(4, 400 * C);
      do_measure(dly, w * C, -1, da, nd, dv, de, dd, bp, b0, bq, e0);
      exp_d = ref_dist(w, 1'b0);
      model_dist = exp_d;
      lat = da - (dly + w * C);
      n_vec++;
      if (nd != 1 || dd !== exp_d || dv !== 1'b1 || de !== 1'b0 || lat < 18 || lat > 20) begin
        n_err++;
        $display("FAIL random_%0d (w=%0dus): got dist=%0d v=%b e=%b pulses=%0d lat=%0d, want dist=%0d v=1 e=0 pulses=1 lat=18..20",
                 t, w, dd, dv, de, nd, lat, exp_d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_nominal();
    test_no_echo();
    test_overrange();
    test_busy_guard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
